// File: rtl/ddr_arbiter.sv
// Two-port DDRAM burst arbiter: port A (ROM download) and port B (frame buffer) share one burst interface.
// Optional feature macro DDR_ARB_ROUND_ROBIN_EN alternates priority after every completed burst.
module ddr_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 64,
    parameter int BURST_W = 8
) (
    input  logic                  clock,
    input  logic                  reset_n,

    input  logic                  a_rd,
    input  logic                  a_wr,
    input  logic [ADDR_W-1:0]     a_addr,
    input  logic [BURST_W-1:0]    a_burst,
    input  logic [DATA_W/8-1:0]   a_mask,
    input  logic [DATA_W-1:0]     a_din,
    output logic                  a_wait,
    output logic                  a_valid,
    output logic                  a_done,
    output logic [DATA_W-1:0]     a_dout,

    input  logic                  b_rd,
    input  logic                  b_wr,
    input  logic [ADDR_W-1:0]     b_addr,
    input  logic [BURST_W-1:0]    b_burst,
    input  logic [DATA_W/8-1:0]   b_mask,
    input  logic [DATA_W-1:0]     b_din,
    output logic                  b_wait,
    output logic                  b_valid,
    output logic                  b_done,
    output logic [DATA_W-1:0]     b_dout,

    output logic                  ddr_rd,
    output logic                  ddr_we,
    output logic [ADDR_W-1:0]     ddr_addr,
    output logic [BURST_W-1:0]    ddr_burst,
    output logic [DATA_W/8-1:0]   ddr_be,
    output logic [DATA_W-1:0]     ddr_din,
    input  logic [DATA_W-1:0]     ddr_dout,
    input  logic                  ddr_busy,
    input  logic                  ddr_valid
);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_RD_CMD  = 2'd1;
    localparam logic [1:0] ST_RD_DATA = 2'd2;
    localparam logic [1:0] ST_WR      = 2'd3;

    localparam logic [BURST_W-1:0] ONE = BURST_W'(1);

    logic [1:0]          state_q, state_d;
    logic                grant_q, grant_d;
    logic [BURST_W-1:0]  beats_q, beats_d;

    logic                a_req, b_req, pick_b;
    logic                g_rd, g_wr;
    logic [ADDR_W-1:0]   g_addr;
    logic [BURST_W-1:0]  g_burst;
    logic [DATA_W/8-1:0] g_mask;
    logic [DATA_W-1:0]   g_din;
    logic                g_wait, g_valid, g_done, wr_beat;

    // A zero-length burst is serviced as a single beat everywhere.
    function automatic logic [BURST_W-1:0] norm_len(input logic [BURST_W-1:0] len);
        return (len == '0) ? ONE : len;
    endfunction

    assign a_req = a_rd | a_wr;
    assign b_req = b_rd | b_wr;

`ifdef DDR_ARB_ROUND_ROBIN_EN
    logic prio_b_q, prio_b_d;
    assign pick_b = b_req & (~a_req | prio_b_q);
`else
    assign pick_b = b_req & ~a_req;
`endif

    always_comb begin
        if (grant_q) begin
            g_rd    = b_rd;
            g_wr    = b_wr;
            g_addr  = b_addr;
            g_burst = norm_len(b_burst);
            g_mask  = b_mask;
            g_din   = b_din;
        end else begin
            g_rd    = a_rd;
            g_wr    = a_wr;
            g_addr  = a_addr;
            g_burst = norm_len(a_burst);
            g_mask  = a_mask;
            g_din   = a_din;
        end
    end

    always_comb begin
        g_wait    = 1'b1;
        g_valid   = 1'b0;
        g_done    = 1'b0;
        wr_beat   = 1'b0;
        ddr_rd    = 1'b0;
        ddr_we    = 1'b0;
        ddr_addr  = '0;
        ddr_burst = '0;
        ddr_be    = '0;
        ddr_din   = '0;
        case (state_q)
            ST_RD_CMD: begin
                ddr_rd    = g_rd;
                ddr_addr  = g_addr;
                ddr_burst = g_burst;
                g_wait    = ddr_busy;
            end
            ST_RD_DATA: begin
                g_valid = ddr_valid;
                g_done  = ddr_valid && (beats_q == ONE);
            end
            ST_WR: begin
                ddr_we    = g_wr;
                ddr_addr  = g_addr;
                ddr_burst = g_burst;
                ddr_be    = g_mask;
                ddr_din   = g_din;
                g_wait    = ddr_busy;
                wr_beat   = g_wr & ~ddr_busy;
                g_done    = wr_beat && (beats_q == ONE);
            end
            default: ;
        endcase
    end

    // Non-granted port is always stalled; read data is broadcast, qualified only by valid.
    assign a_wait  = grant_q ? 1'b1 : g_wait;
    assign b_wait  = grant_q ? g_wait : 1'b1;
    assign a_valid = ~grant_q & g_valid;
    assign b_valid = grant_q & g_valid;
    assign a_done  = ~grant_q & g_done;
    assign b_done  = grant_q & g_done;
    assign a_dout  = ddr_dout;
    assign b_dout  = ddr_dout;

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        beats_d = beats_q;
        case (state_q)
            ST_IDLE: begin
                if (a_req | b_req) begin
                    grant_d = pick_b;
                    beats_d = norm_len(pick_b ? b_burst : a_burst);
                    state_d = (pick_b ? b_rd : a_rd) ? ST_RD_CMD : ST_WR;
                end
            end
            ST_RD_CMD: begin
                if (g_rd && !ddr_busy) state_d = ST_RD_DATA;
            end
            ST_RD_DATA: begin
                if (ddr_valid) begin
                    beats_d = beats_q - ONE;
                    if (beats_q == ONE) state_d = ST_IDLE;
                end
            end
            ST_WR: begin
                if (wr_beat) begin
                    beats_d = beats_q - ONE;
                    if (beats_q == ONE) state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

`ifdef DDR_ARB_ROUND_ROBIN_EN
    always_comb begin
        prio_b_d = prio_b_q;
        if (g_done) prio_b_d = ~grant_q;
    end

    always_ff @(posedge clock) begin
        if (!reset_n) prio_b_q <= 1'b0;
        else          prio_b_q <= prio_b_d;
    end
`endif

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            grant_q <= 1'b0;
            beats_q <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            beats_q <= beats_d;
        end
    end

endmodule

// File: tb/tb_ddr_arbiter.sv
// Self-checking bench for ddr_arbiter: transaction-level model checked every cycle plus directed scenarios.
// Scenario expectations follow DDR_ARB_ROUND_ROBIN_EN when it is defined for the build.
module tb_ddr_arbiter;

    localparam int ADDR_W  = 32;
    localparam int DATA_W  = 64;
    localparam int BURST_W = 8;
    localparam int MASK_W  = DATA_W / 8;

    logic clock = 1'b0;
    logic reset_n = 1'b0;

    logic a_rd, a_wr, b_rd, b_wr;
    logic [ADDR_W-1:0]  a_addr, b_addr;
    logic [BURST_W-1:0] a_burst, b_burst;
    logic [MASK_W-1:0]  a_mask, b_mask;
    logic [DATA_W-1:0]  a_din, b_din;
    logic a_wait, a_valid, a_done, b_wait, b_valid, b_done;
    logic [DATA_W-1:0]  a_dout, b_dout;
    logic ddr_rd, ddr_we;
    logic [ADDR_W-1:0]  ddr_addr;
    logic [BURST_W-1:0] ddr_burst;
    logic [MASK_W-1:0]  ddr_be;
    logic [DATA_W-1:0]  ddr_din, ddr_dout;
    logic ddr_busy, ddr_valid;

    always #5 clock = ~clock;

    ddr_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .BURST_W(BURST_W)) dut (
        .clock(clock), .reset_n(reset_n),
        .a_rd(a_rd), .a_wr(a_wr), .a_addr(a_addr), .a_burst(a_burst), .a_mask(a_mask), .a_din(a_din),
        .a_wait(a_wait), .a_valid(a_valid), .a_done(a_done), .a_dout(a_dout),
        .b_rd(b_rd), .b_wr(b_wr), .b_addr(b_addr), .b_burst(b_burst), .b_mask(b_mask), .b_din(b_din),
        .b_wait(b_wait), .b_valid(b_valid), .b_done(b_done), .b_dout(b_dout),
        .ddr_rd(ddr_rd), .ddr_we(ddr_we), .ddr_addr(ddr_addr), .ddr_burst(ddr_burst),
        .ddr_be(ddr_be), .ddr_din(ddr_din), .ddr_dout(ddr_dout),
        .ddr_busy(ddr_busy), .ddr_valid(ddr_valid)
    );

    int checks = 0;
    int fails = 0;
    int cyc = 0;

    task automatic checkOutput(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            fails++;
            $display("[TB] FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, got, exp);
        end
    endtask

    task automatic reportTimeout(input string name);
        checks++;
        fails++;
        $display("[TB] FAIL %s at cycle %0d: timed out waiting for the DUT", name, cyc);
    endtask

    // Transaction-level model: who owns the interface, whether the read command was taken, beats left.
    int  mOwner = 0;
    int  mLeft = 0;
    int  mPrio = 1;
    bit  mRead = 1'b0;
    bit  mCmdDone = 1'b0;
    bit  modelReady = 1'b0;
    int  grantLog[$];
    int  winner;
    bit  aReq, bReq, beat;

    function automatic int lenOf(input logic [BURST_W-1:0] b);
        return (b == 0) ? 1 : int'(b);
    endfunction

    always @(posedge clock) begin
        cyc++;
        modelReady = 1'b1;
        aReq = a_rd | a_wr;
        bReq = b_rd | b_wr;
        if (!reset_n) begin
            mOwner = 0;
            mLeft = 0;
            mPrio = 1;
            mCmdDone = 1'b0;
        end else if (mOwner == 0) begin
            if (aReq || bReq) begin
                winner = (aReq && bReq) ? mPrio : (aReq ? 1 : 2);
                mOwner = winner;
                mRead = (winner == 1) ? a_rd : b_rd;
                mLeft = lenOf((winner == 1) ? a_burst : b_burst);
                mCmdDone = 1'b0;
                grantLog.push_back(winner);
            end
        end else if (mRead && !mCmdDone) begin
            if (((mOwner == 1) ? a_rd : b_rd) && !ddr_busy) mCmdDone = 1'b1;
        end else begin
            beat = mRead ? ddr_valid : (((mOwner == 1) ? a_wr : b_wr) && !ddr_busy);
            if (beat) begin
                mLeft--;
                if (mLeft == 0) begin
`ifdef DDR_ARB_ROUND_ROBIN_EN
                    mPrio = 3 - mOwner;
`endif
                    mOwner = 0;
                end
            end
        end
    end

    logic eAW, eBW, eAV, eBV, eAD, eBD, eRd, eWe;
    logic [ADDR_W-1:0]  eAddr;
    logic [BURST_W-1:0] eBurst;
    logic [MASK_W-1:0]  eBe;
    logic [DATA_W-1:0]  eDin;
    logic pRd, pWr;
    logic [ADDR_W-1:0]  pAddr;
    logic [BURST_W-1:0] pBurst;
    logic [MASK_W-1:0]  pMask;
    logic [DATA_W-1:0]  pDin;
    logic pWait, pValid, pDone;

    // Expected outputs follow from who owns the bus and which phase of the burst it is in.
    always @(negedge clock) begin
        if (modelReady) begin
            eAW = 1'b1; eBW = 1'b1; eAV = 1'b0; eBV = 1'b0; eAD = 1'b0; eBD = 1'b0;
            eRd = 1'b0; eWe = 1'b0; eAddr = '0; eBurst = '0; eBe = '0; eDin = '0;
            pWait = 1'b1; pValid = 1'b0; pDone = 1'b0;
            pRd    = (mOwner == 2) ? b_rd : a_rd;
            pWr    = (mOwner == 2) ? b_wr : a_wr;
            pAddr  = (mOwner == 2) ? b_addr : a_addr;
            pBurst = BURST_W'(lenOf((mOwner == 2) ? b_burst : a_burst));
            pMask  = (mOwner == 2) ? b_mask : a_mask;
            pDin   = (mOwner == 2) ? b_din : a_din;
            if (mOwner != 0) begin
                if (mRead && !mCmdDone) begin
                    eRd = pRd; eAddr = pAddr; eBurst = pBurst; pWait = ddr_busy;
                end else if (mRead) begin
                    pValid = ddr_valid;
                    pDone = ddr_valid && (mLeft == 1);
                end else begin
                    eWe = pWr; eAddr = pAddr; eBurst = pBurst; eBe = pMask; eDin = pDin;
                    pWait = ddr_busy;
                    pDone = pWr && !ddr_busy && (mLeft == 1);
                end
                if (mOwner == 1) begin eAW = pWait; eAV = pValid; eAD = pDone; end
                else begin eBW = pWait; eBV = pValid; eBD = pDone; end
            end
            checkOutput("a_wait", 64'(a_wait), 64'(eAW));
            checkOutput("b_wait", 64'(b_wait), 64'(eBW));
            checkOutput("a_valid", 64'(a_valid), 64'(eAV));
            checkOutput("b_valid", 64'(b_valid), 64'(eBV));
            checkOutput("a_done", 64'(a_done), 64'(eAD));
            checkOutput("b_done", 64'(b_done), 64'(eBD));
            checkOutput("ddr_rd", 64'(ddr_rd), 64'(eRd));
            checkOutput("ddr_we", 64'(ddr_we), 64'(eWe));
            checkOutput("ddr_addr", 64'(ddr_addr), 64'(eAddr));
            checkOutput("ddr_burst", 64'(ddr_burst), 64'(eBurst));
            checkOutput("ddr_be", 64'(ddr_be), 64'(eBe));
            checkOutput("ddr_din", ddr_din, eDin);
            if (eAV) checkOutput("a_dout", a_dout, ddr_dout);
            if (eBV) checkOutput("b_dout", b_dout, ddr_dout);
        end
    end

    // Event counters observed on the DUT ports, used by the directed scenarios.
    int aValid, bValid, aAcc, bAcc, aDone, bDone, aDoneBeat, bDoneBeat, aDoneCyc, firstBWeCyc, bWaitLowCnt;
    int doneLog[$];

    always @(negedge clock) begin
        if (modelReady) begin
            if (a_valid) aValid++;
            if (b_valid) bValid++;
            if (ddr_we && a_wr && !a_wait) aAcc++;
            if (ddr_we && b_wr && !b_wait) bAcc++;
            if (!b_wait && aDone == 0) bWaitLowCnt++;
            if (ddr_we && !b_wait && firstBWeCyc < 0) firstBWeCyc = cyc;
            if (a_done) begin aDone++; aDoneBeat = aValid + aAcc; aDoneCyc = cyc; doneLog.push_back(1); end
            if (b_done) begin bDone++; bDoneBeat = bValid + bAcc; doneLog.push_back(2); end
        end
    end

    task automatic clearCounters();
        aValid = 0; bValid = 0; aAcc = 0; bAcc = 0; aDone = 0; bDone = 0;
        aDoneBeat = 0; bDoneBeat = 0; aDoneCyc = 0; firstBWeCyc = -1; bWaitLowCnt = 0;
        doneLog.delete();
    endtask

    task automatic stepCycle();
        @(posedge clock);
        #1;
    endtask

    task automatic applyStimulus(input int port, input logic rd, input logic wr,
                                 input logic [ADDR_W-1:0] addr, input logic [BURST_W-1:0] burst,
                                 input logic [MASK_W-1:0] mask, input logic [DATA_W-1:0] din);
        if (port == 1) begin
            a_rd = rd; a_wr = wr; a_addr = addr; a_burst = burst; a_mask = mask; a_din = din;
        end else begin
            b_rd = rd; b_wr = wr; b_addr = addr; b_burst = burst; b_mask = mask; b_din = din;
        end
    endtask

    int expGrants[11];
    int expAlt[4];
    int busySeq[5] = '{1, 0, 1, 0, 0};
    int validSeq[6] = '{0, 1, 1, 0, 1, 1};
    bit seen;

    initial begin
        #100000;
        $display("[TB] FAIL watchdog at cycle %0d: simulation did not complete", cyc);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        applyStimulus(1, 0, 0, '0, '0, '0, '0);
        applyStimulus(2, 0, 0, '0, '0, '0, '0);
        ddr_busy = 1'b0; ddr_valid = 1'b0; ddr_dout = '0;
        clearCounters();
        repeat (2) @(posedge clock);
        #1 reset_n = 1'b1;
        @(negedge clock);
        $display("[TB] reset defaults");
        checkOutput("reset_a_wait", 64'(a_wait), 64'd1);
        checkOutput("reset_b_wait", 64'(b_wait), 64'd1);
        checkOutput("reset_ddr_rd", 64'(ddr_rd), 64'd0);
        checkOutput("reset_ddr_we", 64'(ddr_we), 64'd0);

        // A reads 4 beats at 0x1000 with B idle
        $display("[TB] A read 4 beats");
        stepCycle();
        clearCounters();
        applyStimulus(1, 1, 0, 32'h1000, 8'd4, 8'hFF, '0);
        stepCycle();
        @(negedge clock);
        checkOutput("s1_ddr_rd", 64'(ddr_rd), 64'd1);
        checkOutput("s1_ddr_addr", 64'(ddr_addr), 64'h1000);
        checkOutput("s1_ddr_burst", 64'(ddr_burst), 64'd4);
        stepCycle();
        a_rd = 1'b0;
        for (int i = 0; i < 6; i++) begin
            ddr_valid = validSeq[i][0];
            ddr_dout = 64'hA000 + 64'(i);
            stepCycle();
        end
        ddr_valid = 1'b0;
        @(negedge clock);
        checkOutput("s1_idle_wait", 64'(a_wait), 64'd1);
        checkOutput("s1_valid_count", 64'(aValid), 64'd4);
        checkOutput("s1_done_count", 64'(aDone), 64'd1);
        checkOutput("s1_done_beat", 64'(aDoneBeat), 64'd4);

        // A and B request together
        $display("[TB] simultaneous A read / B write");
        stepCycle();
        clearCounters();
        applyStimulus(1, 1, 0, 32'h2000, 8'd2, 8'hFF, '0);
        applyStimulus(2, 0, 1, 32'h3000, 8'd1, 8'h3C, 64'hCAFE);
        stepCycle();
        @(negedge clock);
        checkOutput("s2_a_first_addr", 64'(ddr_addr), 64'h2000);
        checkOutput("s2_b_wait", 64'(b_wait), 64'd1);
        stepCycle();
        a_rd = 1'b0;
        ddr_valid = 1'b1;
        stepCycle();
        stepCycle();
        ddr_valid = 1'b0;
        stepCycle();
        @(negedge clock);
        checkOutput("s2_b_we", 64'(ddr_we), 64'd1);
        checkOutput("s2_b_be", 64'(ddr_be), 64'h3C);
        stepCycle();
        b_wr = 1'b0;
        stepCycle();
        checkOutput("s2_b_grant_gap", 64'(firstBWeCyc - aDoneCyc), 64'd2);
        checkOutput("s2_b_wait_during_a", 64'(bWaitLowCnt), 64'd0);
        checkOutput("s2_done_count", 64'(doneLog.size()), 64'd2);
        if (doneLog.size() == 2) begin
            checkOutput("s2_done_first", 64'(doneLog[0]), 64'd1);
            checkOutput("s2_done_second", 64'(doneLog[1]), 64'd2);
        end

        // Both ports hold 1-beat writes continuously
        $display("[TB] repeated simultaneous writes");
`ifdef DDR_ARB_ROUND_ROBIN_EN
        expAlt = '{1, 2, 1, 2};
`else
        expAlt = '{1, 1, 1, 1};
`endif
        clearCounters();
        applyStimulus(1, 0, 1, 32'h100, 8'd1, 8'hFF, 64'h1);
        applyStimulus(2, 0, 1, 32'h200, 8'd1, 8'h0F, 64'h2);
        repeat (8) stepCycle();
        a_wr = 1'b0;
        b_wr = 1'b0;
        stepCycle();
        checkOutput("s3_done_count", 64'(doneLog.size()), 64'd4);
        for (int i = 0; i < 4 && i < doneLog.size(); i++)
            checkOutput($sformatf("s3_order_%0d", i), 64'(doneLog[i]), 64'(expAlt[i]));

        // B writes 3 beats against a toggling busy
        $display("[TB] B write 3 beats with busy toggling");
        clearCounters();
        applyStimulus(2, 0, 1, 32'h4000, 8'd3, 8'h0F, 64'h11);
        ddr_busy = 1'b1;
        stepCycle();
        for (int i = 0; i < 5; i++) begin
            ddr_busy = busySeq[i][0];
            b_din = 64'h100 + 64'(i);
            stepCycle();
        end
        b_wr = 1'b0;
        ddr_busy = 1'b0;
        stepCycle();
        checkOutput("s4_accepted", 64'(bAcc), 64'd3);
        checkOutput("s4_done_count", 64'(bDone), 64'd1);
        checkOutput("s4_done_beat", 64'(bDoneBeat), 64'd3);

        // Zero-length read with rd and wr both high
        $display("[TB] A read with burst 0");
        clearCounters();
        applyStimulus(1, 1, 1, 32'h40, 8'd0, 8'hFF, '0);
        stepCycle();
        @(negedge clock);
        checkOutput("s5_rd_wins", 64'(ddr_rd), 64'd1);
        checkOutput("s5_no_we", 64'(ddr_we), 64'd0);
        checkOutput("s5_burst_one", 64'(ddr_burst), 64'd1);
        stepCycle();
        a_rd = 1'b0;
        a_wr = 1'b0;
        ddr_valid = 1'b1;
        ddr_dout = 64'hDEADBEEF;
        stepCycle();
        stepCycle();
        ddr_valid = 1'b0;
        stepCycle();
        checkOutput("s5_valid_count", 64'(aValid), 64'd1);
        checkOutput("s5_done_count", 64'(aDone), 64'd1);

        // Reset in the middle of an 8-beat read
        $display("[TB] reset during read data");
        clearCounters();
        applyStimulus(1, 1, 0, 32'h5000, 8'd8, 8'hFF, '0);
        stepCycle();
        stepCycle();
        a_rd = 1'b0;
        ddr_valid = 1'b1;
        stepCycle();
        stepCycle();
        ddr_valid = 1'b0;
        reset_n = 1'b0;
        stepCycle();
        reset_n = 1'b1;
        @(negedge clock);
        checkOutput("s6_a_wait", 64'(a_wait), 64'd1);
        checkOutput("s6_ddr_rd", 64'(ddr_rd), 64'd0);
        stepCycle();
        ddr_valid = 1'b1;
        repeat (3) stepCycle();
        ddr_valid = 1'b0;
        stepCycle();
        checkOutput("s6_valid_count", 64'(aValid), 64'd2);
        checkOutput("s6_done_count", 64'(aDone), 64'd0);

        // Longest burst: 255 write beats
        $display("[TB] A write 255 beats");
        clearCounters();
        applyStimulus(1, 0, 1, 32'h6000, 8'd255, 8'hAA, 64'h55);
        seen = 1'b0;
        for (int i = 0; i < 400 && !seen; i++) begin
            @(negedge clock);
            if (a_done) seen = 1'b1;
        end
        if (!seen) reportTimeout("s7_done_wait");
        stepCycle();
        a_wr = 1'b0;
        stepCycle();
        checkOutput("s7_accepted", 64'(aAcc), 64'd255);
        checkOutput("s7_done_count", 64'(aDone), 64'd1);
        checkOutput("s7_done_beat", 64'(aDoneBeat), 64'd255);

        // Pin the model's own grant history
`ifdef DDR_ARB_ROUND_ROBIN_EN
        expGrants = '{1, 1, 2, 1, 2, 1, 2, 2, 1, 1, 1};
`else
        expGrants = '{1, 1, 2, 1, 1, 1, 1, 2, 1, 1, 1};
`endif
        checkOutput("model_grant_count", 64'(grantLog.size()), 64'd11);
        for (int i = 0; i < 11 && i < grantLog.size(); i++)
            checkOutput($sformatf("model_grant_%0d", i), 64'(grantLog[i]), 64'(expGrants[i]));

        repeat (2) stepCycle();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
